// File: rtl/sass_t.sv
// SASS line transmitter: start(0), data_l bits MSB first, stop(1); each bit held DIV*t clocks, first bit 1 clk after accept.
// No queueing: send is level-sensitive and only accepted while idle; requests during a frame are dropped.
module sass_t #(
  parameter int clk_f  = 50_000_000,
  parameter int range  = 1_000_000,
  parameter int t      = 300,
  parameter int data_l = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [data_l-1:0] data,
  input  logic              send,
  output logic              s,
  output logic              busy,
  output logic              done
);

  localparam int DIV = clk_f / range;
  localparam int PW  = $clog2(DIV) + 1;
  localparam int TW  = $clog2(t) + 1;
  localparam int IW  = $clog2(data_l) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_n;
  logic [PW-1:0]     pre, pre_n;
  logic [TW-1:0]     bt, bt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [data_l-1:0] shreg, shreg_n;
  logic              s_n, busy_n, done_n;
  logic              tick, bnd;

  assign tick = (pre == PW'(DIV - 1));
  assign bnd  = tick && (bt == TW'(t - 1));

  always_comb begin
    state_n = state;
    pre_n   = pre;
    bt_n    = bt;
    idx_n   = idx;
    shreg_n = shreg;

    if (state != IDLE) begin
      if (tick) begin
        pre_n = '0;
        bt_n  = bnd ? '0 : bt + TW'(1);
      end else begin
        pre_n = pre + PW'(1);
      end
    end

    case (state)
      IDLE: begin
        if (send) begin
          shreg_n = data;
          pre_n   = '0;
          bt_n    = '0;
          idx_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bnd) begin
          state_n = DATA;
          idx_n   = IW'(data_l - 1);
        end
      end
      DATA: begin
        if (bnd) begin
          shreg_n = shreg << 1;
          if (idx == '0) state_n = STOP;
          else           idx_n   = idx - IW'(1);
        end
      end
      STOP: begin
        if (bnd) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are computed from next state so they register in lockstep with it.
    s_n    = (state_n == START) ? 1'b0 :
             (state_n == DATA)  ? shreg_n[data_l-1] : 1'b1;
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (pre_n == PW'(DIV - 1)) && (bt_n == TW'(t - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pre   <= '0;
      bt    <= '0;
      idx   <= '0;
      shreg <= '0;
      s     <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      bt    <= bt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      s     <= s_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_sass_t.sv
// Bench for sass_t: a TB=6 instance and a TB=1 instance, checked per clock against a frame model.
module tb_sass_t;

  localparam int L  = 4;
  localparam int TB = 6;
  localparam int FR = (L + 2) * TB;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [L-1:0] data = '0, data1 = '0;
  logic         send = 1'b0, send1 = 1'b0;
  logic         s, busy, done;
  logic         s1, busy1, done1;

  int tests = 0;
  int fails = 0;

  sass_t #(.clk_f(10), .range(5), .t(3), .data_l(L)) dut (
    .clk(clk), .rst(rst), .data(data), .send(send), .s(s), .busy(busy), .done(done)
  );

  sass_t #(.clk_f(7), .range(7), .t(1), .data_l(L)) dut1 (
    .clk(clk), .rst(rst), .data(data1), .send(send1), .s(s1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  // Line level k clocks into a frame carrying word d with tb clocks per bit.
  function automatic logic exp_s(input logic [L-1:0] d, input int k, input int tb);
    int b;
    b = k / tb;
    if (b == 0) return 1'b0;
    if (b <= L) return d[L - b];
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; send = 1'b1; send1 = 1'b1; data = 4'($urandom); data1 = 4'($urandom);
    repeat (2) @(negedge clk);
    tests++; if (s !== 1'b1)     begin fails++; $display("FAIL reset_s got %b want 1", s); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)  begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (s1 !== 1'b1)    begin fails++; $display("FAIL reset_s1 got %b want 1", s1); end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    rst = 1'b0; send = 1'b0; send1 = 1'b0;
    @(negedge clk);
  endtask

  // One frame; at cycle poke_k (if < FR) a stray send with junk data must be ignored.
  task automatic test_frame(input logic [L-1:0] d, input int poke_k);
    int ndone;
    ndone = 0;
    data = d; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int k = 0; k < FR; k++) begin
      tests++; if (s !== exp_s(d, k, TB))
        begin fails++; $display("FAIL frame_s d=%b k=%0d got %b want %b", d, k, s, exp_s(d, k, TB)); end
      tests++; if (busy !== 1'b1)
        begin fails++; $display("FAIL frame_busy d=%b k=%0d got %b want 1", d, k, busy); end
      tests++; if (done !== (k == FR - 1))
        begin fails++; $display("FAIL frame_done d=%b k=%0d got %b want %b", d, k, done, k == FR - 1); end
      if (done === 1'b1) ndone++;
      data = 4'($urandom);
      send = (k == poke_k);
      @(negedge clk);
    end
    send = 1'b0;
    tests++; if (s !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin fails++; $display("FAIL frame_idle d=%b got s=%b busy=%b done=%b want 1 0 0", d, s, busy, done); end
    tests++; if (ndone != 1)
      begin fails++; $display("FAIL frame_done_count d=%b got %0d want 1", d, ndone); end
    @(negedge clk);
    tests++; if (busy !== 1'b0)
      begin fails++; $display("FAIL frame_no_queue d=%b poke=%0d got busy=%b want 0", d, poke_k, busy); end
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 8; i++) test_frame(4'($urandom), int'($urandom_range(0, FR + 4)));
  endtask

  task automatic test_back_to_back();
    logic [L-1:0] d;
    int m;
    d = 4'($urandom);
    data = d; send = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2 * (FR + 1); k++) begin
      m = k % (FR + 1);
      tests++; if (s !== ((m == FR) ? 1'b1 : exp_s(d, m, TB)))
        begin fails++; $display("FAIL b2b_s d=%b k=%0d got %b", d, k, s); end
      tests++; if (busy !== (m != FR))
        begin fails++; $display("FAIL b2b_busy k=%0d got %b want %b", k, busy, m != FR); end
      tests++; if (done !== (m == FR - 1))
        begin fails++; $display("FAIL b2b_done k=%0d got %b want %b", k, done, m == FR - 1); end
      if (k == 2 * FR) send = 1'b0;
      @(negedge clk);
    end
    tests++; if (busy !== 1'b0)
      begin fails++; $display("FAIL b2b_release got busy=%b want 0", busy); end
  endtask

  task automatic test_midframe_reset();
    logic [L-1:0] d;
    d = 4'($urandom);
    data = d; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tests++; if (s !== exp_s(d, k, TB))
        begin fails++; $display("FAIL rstmid_s k=%0d got %b want %b", k, s, exp_s(d, k, TB)); end
      if (k == 14) begin rst = 1'b1; send = 1'b1; data = 4'($urandom); end
      @(negedge clk);
    end
    tests++; if (s !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      begin fails++; $display("FAIL rstmid_after got s=%b busy=%b done=%b want 1 0 0", s, busy, done); end
    rst = 1'b0; send = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0)
      begin fails++; $display("FAIL rst_vs_send got busy=%b want 0", busy); end
    test_frame(4'($urandom), -1);
  endtask

  task automatic test_tb1();
    logic [L-1:0] words [5];
    logic [L-1:0] d;
    int m;
    words[0] = 4'b0101;
    for (int i = 1; i < 5; i++) words[i] = 4'($urandom);
    foreach (words[i]) begin
      d = words[i];
      data1 = d; send1 = 1'b1;
      @(negedge clk);
      send1 = 1'b0;
      for (int k = 0; k < L + 2; k++) begin
        tests++; if (s1 !== exp_s(d, k, 1) || busy1 !== 1'b1 || done1 !== (k == L + 1))
          begin fails++; $display("FAIL tb1_frame d=%b k=%0d got s=%b busy=%b done=%b want %b 1 %b",
                                  d, k, s1, busy1, done1, exp_s(d, k, 1), k == L + 1); end
        @(negedge clk);
      end
      tests++; if (s1 !== 1'b1 || busy1 !== 1'b0)
        begin fails++; $display("FAIL tb1_idle got s=%b busy=%b want 1 0", s1, busy1); end
    end
    d = 4'($urandom);
    data1 = d; send1 = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2 * (L + 3); k++) begin
      m = k % (L + 3);
      tests++; if (s1 !== ((m == L + 2) ? 1'b1 : exp_s(d, m, 1)) || busy1 !== (m != L + 2))
        begin fails++; $display("FAIL tb1_b2b k=%0d got s=%b busy=%b", k, s1, busy1); end
      if (k == 2 * (L + 3) - 2) send1 = 1'b0;
      @(negedge clk);
    end
    tests++; if (busy1 !== 1'b0)
      begin fails++; $display("FAIL tb1_release got busy=%b want 0", busy1); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame(4'b1011, -1);
    test_frame(4'b1111, 9);
    test_random_frames();
    test_back_to_back();
    test_midframe_reset();
    test_tb1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
